// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with load, start, pause and expiry reporting.
module countdown_timer #(
  parameter int unsigned DEFAULT_TENS = 6,
  parameter int unsigned DEFAULT_ONES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [DW-1:0]   tens_next, ones_next;
  logic            done_next;
  logic            value_zero;
  logic            value_one;

  // Saturate any out-of-range BCD digit to 9.
  function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d);
    return (d > DW'(9)) ? DW'(9) : d;
  endfunction

  assign value_zero = (tens == '0) && (ones == '0);
  assign value_one  = (tens == '0) && (ones == DW'(1));

  // State register and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tens    <= clamp_digit(DW'(DEFAULT_TENS));
      ones    <= clamp_digit(DW'(DEFAULT_ONES));
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      tens    <= tens_next;
      ones    <= ones_next;
      running <= (state_next == RUN);
      expired <= (state_next == EXPIRED);
      done    <= done_next;
    end
  end

  // Next-state, next-value and done-pulse decision (load > pause > start).
  always_comb begin
    state_next = state;
    tens_next  = tens;
    ones_next  = ones;
    done_next  = 1'b0;
    case (state)
      IDLE, PAUSED: begin
        if (load) begin
          state_next = IDLE;
          tens_next  = clamp_digit(load_tens);
          ones_next  = clamp_digit(load_ones);
        end else if (pause) begin
          state_next = state;
        end else if (start) begin
          if (value_zero) begin
            state_next = EXPIRED;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        // Load is ignored while counting; tick decrements, pause suspends.
        if (tick && !value_zero) begin
          if (ones == '0) begin
            ones_next = DW'(9);
            tens_next = tens - DW'(1);
          end else begin
            ones_next = ones - DW'(1);
          end
        end
        if (tick && value_one) begin
          state_next = EXPIRED;
          done_next  = 1'b1;
        end else if (pause) begin
          state_next = PAUSED;
        end
      end
      EXPIRED: begin
        if (load) begin
          state_next = IDLE;
          tens_next  = clamp_digit(load_tens);
          ones_next  = clamp_digit(load_ones);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL provide parameter DEFAULT_TENS, default 6: tens digit loaded at reset (0-9).
REQ-002 SHALL provide parameter DEFAULT_ONES, default 0: ones digit loaded at reset (0-9).
REQ-003 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port tick  input  1  one-cycle decrement pulse, driven by the upstream count-to-10 timeout output.
REQ-006 SHALL provide port load  input  1  load request for load_tens/load_ones.
REQ-007 SHALL provide port load_tens  input  4  BCD tens digit to load.
REQ-008 SHALL provide port load_ones  input  4  BCD ones digit to load.
REQ-009 SHALL provide port start  input  1  level/pulse request to begin or resume counting.
REQ-010 SHALL provide port pause  input  1  level/pulse request to suspend counting.
REQ-011 SHALL provide port tens  output  4  current BCD tens digit, registered.
REQ-012 SHALL provide port ones  output  4  current BCD ones digit, registered.
REQ-013 SHALL provide port running  output  1  high while state is RUN, registered.
REQ-014 SHALL provide port expired  output  1  high while state is EXPIRED, registered.
REQ-015 SHALL provide port done  output  1  one-cycle pulse on entry to EXPIRED, registered.

Function
REQ-016 SHALL implement the states IDLE, RUN, PAUSED and EXPIRED.
REQ-017 SHALL give input priority load > pause > start within a cycle.
REQ-018 SHALL, in IDLE, PAUSED or EXPIRED with load=1, latch load_tens/load_ones into tens/ones on the next edge and go to IDLE, clearing expired.
REQ-019 SHALL clamp any loaded digit greater than 9 to 9.
REQ-020 SHALL ignore load while in RUN, leaving the digits and the state unchanged.
REQ-021 SHALL, on start=1 with pause=0 and load=0, move IDLE or PAUSED to RUN if the value is non-zero.
REQ-022 SHALL, on start in IDLE or PAUSED with value 00, move to EXPIRED and assert done for one cycle.
REQ-023 SHALL, on pause=1 in RUN, move to PAUSED; pause and start together in RUN or PAUSED SHALL result in PAUSED.
REQ-024 SHALL, on tick=1 in RUN, decrement the BCD value by one on the same edge: ones>0 -> ones-1; ones=0 -> ones=9, tens-1.
REQ-025 SHALL ignore tick in IDLE, PAUSED and EXPIRED; the value never decrements below 00 and never wraps to 99.
REQ-026 SHALL, on a tick in RUN when the value is 01 (tens=0, ones=1), set the value to 00, enter EXPIRED and assert done on that same edge.
REQ-027 SHALL, on tick and pause in the same RUN cycle, apply the decrement and then enter PAUSED; if that decrement reaches 00, EXPIRED wins.
REQ-028 SHALL hold done high for exactly one cycle per EXPIRED entry, including when start or tick remain asserted.
REQ-029 SHALL remain in EXPIRED until load or reset, ignoring start, pause and tick.
REQ-030 SHALL keep the digits at all times as valid BCD (0-9).
REQ-031 SHALL have zero-cycle decision latency: outputs reflect a sampled input on the edge that samples it, with no additional pipeline.

Reset
REQ-032 SHALL, when rst=0 at a rising edge, force state IDLE, tens=DEFAULT_TENS, ones=DEFAULT_ONES, running=0, expired=0, done=0, overriding all other inputs.
REQ-033 SHALL, on reset asserted mid-RUN or in the same cycle as a final tick, discard the tick and suppress done.
REQ-034 SHALL resume normal operation on the first edge with rst=1, sampling inputs on that edge.

Verification
REQ-035 SHALL be verified by: reset, start, 60 ticks -> 60,59..01,00; done pulses once with the 01->00 tick; expired=1, running=0.
REQ-036 SHALL be verified by: load 1 and 0xC while in IDLE -> tens=1, ones=9 (clamped); start then 1 tick -> 18; running=1.
REQ-037 SHALL be verified by: RUN at 20, tick and pause in the same cycle -> 19 and PAUSED; 3 further ticks -> still 19; start -> RUN.
REQ-038 SHALL be verified by: RUN at 35, load 0 and 5 -> ignored, still 35; pause, then load 0 and 5 -> 05 and IDLE.
REQ-039 SHALL be verified by: load 00 then start -> EXPIRED and done pulse the next cycle; start held 5 cycles -> no further done.
REQ-040 SHALL be verified by: RUN at 01, rst=0 coincident with tick -> 60, IDLE, done=0 for all following cycles.
